// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Transmit queue that sits between a CPU/bus writer and a byte-wide UART
//   serializer. Bytes are queued in a circular buffer and handed one at a
//   time to the serializer by a small drain FSM that waits for the
//   serializer to acknowledge (busy rising) and finish (busy falling)
//   before the next byte is launched.
//
// Parameters
//   DEPTH         queue entries (power of two, 2..256)
//   AW            address width, log2(DEPTH)
//   PAYLOAD_BITS  byte width shared with the serializer
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous active-high reset
//   wr_en/wr_data push request and byte from the writer side
//   clr           synchronous flush of queued bytes and the overflow flag
//   full/empty    occupancy flags
//   count         entries currently queued
//   overflow      sticky flag: a push arrived while full and was dropped
//   all_done      queue empty, drain FSM idle and serializer not busy
//   uart_tx_en    one-cycle send strobe to the serializer
//   uart_tx_data  registered byte for the serializer
//   uart_tx_busy  serializer busy; rises the cycle after it samples uart_tx_en
module uart_tx_fifo #(
  parameter int DEPTH        = 16,
  parameter int AW           = 4,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [PAYLOAD_BITS-1:0] wr_data,
  input  logic                    clr,
  output logic                    full,
  output logic                    empty,
  output logic [AW:0]             count,
  output logic                    overflow,
  output logic                    all_done,
  output logic                    uart_tx_en,
  output logic [PAYLOAD_BITS-1:0] uart_tx_data,
  input  logic                    uart_tx_busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [PAYLOAD_BITS-1:0] mem [DEPTH];

  state_e                  state_q,    state_d;
  logic [AW-1:0]           wptr_q,     wptr_d;
  logic [AW-1:0]           rptr_q,     rptr_d;
  logic [AW:0]             count_q,    count_d;
  logic                    overflow_q, overflow_d;
  logic                    tx_en_q,    tx_en_d;
  logic [PAYLOAD_BITS-1:0] tx_data_q,  tx_data_d;

  logic push_ok;
  logic launch;

  // Status flags come only from registered state (plus the serializer's busy).
  assign full         = (count_q == CNT_FULL);
  assign empty        = (count_q == '0);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign all_done     = empty && (state_q == IDLE) && !uart_tx_busy;
  assign uart_tx_en   = tx_en_q;
  assign uart_tx_data = tx_data_q;

  // A flush wins over both a push and a launch in the same cycle. The full
  // test uses the registered count, so a push while full is dropped even if
  // a pop frees a slot on the same edge.
  always_comb begin
    push_ok = wr_en && !full && !clr;
    launch  = (state_q == IDLE) && !empty && !uart_tx_busy && !clr;
  end

  // Queue bookkeeping
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clr) begin
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push_ok) wptr_d = wptr_q + PTR_ONE;
      if (launch)  rptr_d = rptr_q + PTR_ONE;
      if (push_ok && !launch) begin
        count_d = count_q + CNT_ONE;
      end else if (!push_ok && launch) begin
        count_d = count_q - CNT_ONE;
      end
      if (wr_en && full) overflow_d = 1'b1;
    end
  end

  // Drain FSM: one byte outstanding at the serializer at a time. The strobe
  // is high only while in LAUNCH; the data register holds until the next
  // launch. clr does not touch this path, so a launched byte completes.
  always_comb begin
    state_d   = state_q;
    tx_en_d   = 1'b0;
    tx_data_d = tx_data_q;
    case (state_q)
      IDLE: begin
        if (launch) begin
          state_d   = LAUNCH;
          tx_en_d   = 1'b1;
          tx_data_d = mem[rptr_q];
        end
      end
      LAUNCH:    state_d = WAIT_ACK;
      WAIT_ACK:  if (uart_tx_busy)  state_d = WAIT_DONE;
      WAIT_DONE: if (!uart_tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_en_q    <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tx_en_q    <= tx_en_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem[wptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int PB    = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [PB-1:0] wr_data;
  logic          clr;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          all_done;
  logic          uart_tx_en;
  logic [PB-1:0] uart_tx_data;
  logic          uart_tx_busy;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW), .PAYLOAD_BITS(PB)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .clr          (clr),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
    .all_done     (all_done),
    .uart_tx_en   (uart_tx_en),
    .uart_tx_data (uart_tx_data),
    .uart_tx_busy (uart_tx_busy)
  );

  // Reference serializer: samples the strobe, then stays busy for a random
  // 1..4 cycles. ser_hold forces busy high to stall the queue.
  logic ser_hold = 1'b0;
  int   ser_left = 0;
  assign uart_tx_busy = ser_hold || (ser_left != 0);

  always @(posedge clk) begin
    if (uart_tx_en)         ser_left <= $urandom_range(4, 1);
    else if (ser_left != 0) ser_left <= ser_left - 1;
  end

  // Reference queue: the bytes the FIFO should be holding, oldest first.
  logic [PB-1:0] sb[$];
  bit            m_ovf   = 1'b0;
  bit            mon_en  = 1'b0;
  bit            prev_en = 1'b0;
  int            n_vec   = 0;
  int            n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Occupancy before an edge is the queue size at that edge; launches are
  // removed by the monitor on the negedge after they appear.
  always @(posedge clk) begin
    if (reset || clr) begin
      sb.delete();
      m_ovf = 1'b0;
    end else if (wr_en) begin
      if (sb.size() >= DEPTH) m_ovf = 1'b1;
      else                    sb.push_back(wr_data);
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (uart_tx_en) begin
        chk("tx_en_back_to_back", int'(prev_en), 0);
        if (sb.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL spurious_tx: emitted %0h, nothing queued (t=%0t)", uart_tx_data, $time);
        end else begin
          chk("tx_data_order", int'(uart_tx_data), int'(sb.pop_front()));
        end
      end
      prev_en = uart_tx_en;
      chk("count",    int'(count),    sb.size());
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("full",     int'(full),     int'(sb.size() == DEPTH));
      chk("empty",    int'(empty),    int'(sb.size() == 0));
    end
  end

  task automatic wait_done(input string name, input int maxc);
    for (int i = 0; i < maxc && !all_done; i++) tick();
    chk(name, int'(all_done), 1);
  endtask

  task automatic push(input logic [PB-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int guard;
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    clr     = 1'b0;
    repeat (3) tick();

    chk("rst_empty",    int'(empty),        1);
    chk("rst_full",     int'(full),         0);
    chk("rst_count",    int'(count),        0);
    chk("rst_overflow", int'(overflow),     0);
    chk("rst_all_done", int'(all_done),     1);
    chk("rst_tx_en",    int'(uart_tx_en),   0);
    chk("rst_tx_data",  int'(uart_tx_data), 0);
    mon_en = 1'b1;
    reset  = 1'b0;
    tick();

    // Single byte latency
    push(8'h41);
    chk("lat_c1_count", int'(count),      1);
    chk("lat_c1_tx_en", int'(uart_tx_en), 0);
    tick();
    chk("lat_c2_tx_en",   int'(uart_tx_en),   1);
    chk("lat_c2_tx_data", int'(uart_tx_data), 8'h41);
    chk("lat_c2_count",   int'(count),        0);
    wait_done("lat_all_done", 40);

    // Fill while stalled, then overflow
    ser_hold = 1'b1;
    for (int i = 0; i < DEPTH; i++) push(8'(8'h30 + i));
    push(8'h55);
    chk("fill_full",     int'(full),     1);
    chk("fill_count",    int'(count),    16);
    chk("fill_overflow", int'(overflow), 1);
    tick();
    ser_hold = 1'b0;
    wait_done("fill_drain", 300);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("fill_clr_overflow", int'(overflow), 0);

    // Randomly paced stream with pointer wrap
    n = 0;
    guard = 0;
    while (n < 20 && guard < 2000) begin
      if ($urandom_range(1, 0) == 1 && !full) begin
        wr_en   = 1'b1;
        wr_data = 8'(n);
        n++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
      guard++;
    end
    wr_en = 1'b0;
    chk("stream_pushed", n, 20);
    wait_done("stream_drain", 300);

    // Flush with a push in the same cycle while one byte is in flight
    for (int i = 0; i < 4; i++) push(8'(8'hA0 + i));
    chk("clr_pre_count", int'(count), 3);
    wr_en   = 1'b1;
    wr_data = 8'h77;
    clr     = 1'b1;
    tick();
    wr_en = 1'b0;
    clr   = 1'b0;
    chk("clr_count",    int'(count),    0);
    chk("clr_overflow", int'(overflow), 0);
    wait_done("clr_inflight_done", 40);

    // Flush in the cycle a launch would happen
    ser_hold = 1'b1;
    push(8'hB0);
    push(8'hB1);
    ser_hold = 1'b0;
    clr      = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_launch_count", int'(count),      0);
    chk("clr_launch_tx_en", int'(uart_tx_en), 0);
    repeat (5) tick();
    chk("clr_launch_all_done", int'(all_done), 1);

    // Full with a simultaneous pop: push still dropped
    ser_hold = 1'b1;
    for (int i = 0; i < DEPTH; i++) push(8'($urandom));
    ser_hold = 1'b0;
    push(8'hEE);
    chk("fullpop_count",    int'(count),    15);
    chk("fullpop_overflow", int'(overflow), 1);
    chk("fullpop_full",     int'(full),     0);
    wait_done("fullpop_drain", 300);
    clr = 1'b1;
    tick();
    clr = 1'b0;

    // Reset while the FSM waits for the serializer, with bytes queued
    for (int i = 0; i < 6; i++) begin
      if (i == 2) ser_hold = 1'b1;
      push(8'(8'hC0 + i));
    end
    chk("rstmid_pre_count",    int'(count),    5);
    chk("rstmid_pre_all_done", int'(all_done), 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid_count", int'(count),      0);
    chk("rstmid_tx_en", int'(uart_tx_en), 0);
    chk("rstmid_empty", int'(empty),      1);
    ser_hold = 1'b0;
    #1;
    chk("rstmid_all_done", int'(all_done), 1);
    repeat (10) tick();
    chk("rstmid_no_launch_count", int'(count), 0);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
